hps_reset_sequencer: RTL and testbench

Parametrised, multi-channel successor to the per-signal reset edge detectors on the HPS reset-request path. It synchronises NUM_CH asynchronous request inputs and detects a configurable edge on each. It then emits one fixed-length active-high pulse at a time, in priority order, with a programmable holdoff between pulses. Its outputs drive the HPS cold/warm/debug reset-request inputs (inverted at the top level) in the FPGA system top.

---
 rtl/hps_reset_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hps_reset_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_reset_sequencer.sv
// ============================================================================
// Module      : hps_reset_sequencer
// Description : Multi-channel reset-request sequencer. Synchronises NUM_CH
//               asynchronous request levels, detects a per-channel edge,
//               latches requests and serves them one at a time in priority
//               order (channel 0 highest) as fixed-length active-high pulses
//               separated by a programmable holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hps_reset_sequencer #(
    parameter int                        NUM_CH      = 3,
    parameter int                        CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0]   PULSE_LEN   = {8'd32, 8'd2, 8'd6},
    parameter logic [NUM_CH-1:0]         EDGE_TYPE   = {NUM_CH{1'b1}},
    parameter int                        RETRIGGER   = 0,
    parameter int                        HOLDOFF     = 4,
    parameter int                        SYNC_STAGES = 2,
    localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] signal_in,
    output logic [NUM_CH-1:0] pulse_out,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] pending
);

    // A synchroniser shallower than two flops gives no metastability margin,
    // so the depth is clamped to at least two.
    localparam int               SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Edge detection stays masked until the chain and the history flop have
    // all been refilled from the live inputs after reset.
    localparam int               ARM_DONE = SYNC_N + 1;
    localparam int               ARM_W    = $clog2(ARM_DONE + 1);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLDOFF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Registered state
    state_t            state_q,     state_d;
    logic [NUM_CH-1:0] sync_q [SYNC_N];
    logic [NUM_CH-1:0] sync_d [SYNC_N];
    logic [NUM_CH-1:0] hist_q,      hist_d;
    logic [ARM_W-1:0]  arm_cnt_q,   arm_cnt_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [NUM_CH-1:0] pulse_out_q, pulse_out_d;
    logic              busy_q,      busy_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [NUM_CH-1:0] pending_q,   pending_d;

    // Combinational helpers
    logic [NUM_CH-1:0] w_sync_out;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic              w_armed;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [CH_W-1:0]   w_grant_idx;
    logic [NUM_CH-1:0] w_served_oh;
    logic [NUM_CH-1:0] w_absorb;

    // Pulse length of a channel, with a zero length promoted to one cycle.
    function automatic logic [CNT_W-1:0] len_of(input logic [CH_W-1:0] idx);
        logic [CNT_W-1:0] len;
        len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == CH_W'(i)) begin
                len = PULSE_LEN[i*CNT_W +: CNT_W];
            end
        end
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    assign w_sync_out = sync_q[SYNC_N-1];

    // Synchroniser shift, history capture, arm mask and qualified edge detect.
    always_comb begin
        sync_d[0] = signal_in;
        for (int i = 1; i < SYNC_N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d    = w_sync_out;
        w_rise    = w_sync_out & ~hist_q;
        w_fall    = ~w_sync_out & hist_q;
        w_armed   = (arm_cnt_q == ARM_W'(ARM_DONE));
        arm_cnt_d = w_armed ? arm_cnt_q : (arm_cnt_q + ARM_W'(1));
        w_edge    = w_armed ? ((w_rise & EDGE_TYPE) | (w_fall & ~EDGE_TYPE)) : '0;
    end

    // Sequencer next-state: grant arbitration, pulse/holdoff counting and
    // request latching.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_out_d = pulse_out_q;
        active_ch_d = active_ch_q;
        w_absorb    = '0;

        // Lowest set pending bit wins.
        w_grant_oh  = pending_q & (~pending_q + NUM_CH'(1));
        w_grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_grant_idx = CH_W'(i);
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            w_served_oh[i] = (active_ch_q == CH_W'(i));
        end

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    state_d     = ST_PULSE;
                    active_ch_d = w_grant_idx;
                    cnt_d       = len_of(w_grant_idx);
                    pulse_out_d = w_grant_oh;
                    // An edge on the granted channel in its grant cycle is
                    // part of the request being served.
                    w_absorb    = w_grant_oh;
                end
            end

            ST_PULSE: begin
                // Edges on the channel being pulsed never become new requests.
                w_absorb = w_served_oh;
                if ((RETRIGGER != 0) && (|(w_edge & w_served_oh))) begin
                    cnt_d = len_of(active_ch_q);
                end else if (cnt_q == CNT_W'(1)) begin
                    pulse_out_d = '0;
                    if (HOLDOFF > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_CNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_HOLDOFF: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                pulse_out_d = '0;
            end
        endcase

        pending_d = (pending_q & ~w_grant_oh_masked(state_q, w_grant_oh)) |
                    (w_edge & ~w_absorb);
        busy_d    = (state_d != ST_IDLE);
    end

    // Grant clears its pending bit only when a grant actually happens.
    function automatic logic [NUM_CH-1:0] w_grant_oh_masked(input state_t st,
                                                            input logic [NUM_CH-1:0] oh);
        return (st == ST_IDLE) ? oh : '0;
    endfunction

    // All state registers, cleared synchronously by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= '0;
            end
            hist_q      <= '0;
            arm_cnt_q   <= '0;
            cnt_q       <= '0;
            pulse_out_q <= '0;
            busy_q      <= 1'b0;
            active_ch_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= sync_d[i];
            end
            hist_q      <= hist_d;
            arm_cnt_q   <= arm_cnt_d;
            cnt_q       <= cnt_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            active_ch_q <= active_ch_d;
            pending_q   <= pending_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign active_ch = active_ch_q;
    assign pending   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_hps_reset_sequencer.sv
// ============================================================================
// Module      : tb_hps_reset_sequencer
// Description : Self-checking bench for hps_reset_sequencer. Three instances
//               (defaults, retrigger enabled, falling-edge/zero-length/no
//               holdoff) share one clock and reset. Expected pulses are
//               queued by the stimulus and matched by a pulse monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hps_reset_sequencer;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] si     [NDUT];
    logic [2:0] po     [NDUT];
    logic       busy_a [NDUT];
    logic [1:0] ach    [NDUT];
    logic [2:0] pend   [NDUT];

    always #5 clk = ~clk;

    hps_reset_sequencer u_dut0 (
        .clk(clk), .reset(reset), .signal_in(si[0]), .pulse_out(po[0]),
        .busy(busy_a[0]), .active_ch(ach[0]), .pending(pend[0])
    );

    hps_reset_sequencer #(.RETRIGGER(1)) u_dut1 (
        .clk(clk), .reset(reset), .signal_in(si[1]), .pulse_out(po[1]),
        .busy(busy_a[1]), .active_ch(ach[1]), .pending(pend[1])
    );

    hps_reset_sequencer #(
        .PULSE_LEN({8'd32, 8'd2, 8'd0}),
        .EDGE_TYPE(3'b101),
        .HOLDOFF(0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .signal_in(si[2]), .pulse_out(po[2]),
        .busy(busy_a[2]), .active_ch(ach[2]), .pending(pend[2])
    );

    typedef struct {
        int dut;
        int ch;
        int width;
        int gap;   // low cycles before the pulse, -1 = don't care
        int lat;   // cycles from stimulus edge k to first pulse cycle, -1 = don't care
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mark      [NDUT];
    int   run_len   [NDUT];
    int   cur_ch    [NDUT];
    int   gap_cnt   [NDUT];
    int   start_gap [NDUT];
    int   start_lat [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input int d, input int ch, input int w, input int gap, input int lat);
        exp_t e;
        e.dut = d; e.ch = ch; e.width = w; e.gap = gap; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse(input int d);
        int ch;
        ch = -1;
        for (int i = 0; i < 3; i++) begin
            if (po[d][i] && ch < 0) ch = i;
        end
        chk($sformatf("pulse_onehot_dut%0d", d), $countones(po[d]), 1);
        cur_ch[d]    = ch;
        run_len[d]   = 1;
        start_gap[d] = gap_cnt[d];
        start_lat[d] = cyc - mark[d];
    endtask

    task automatic finish_pulse(input int d);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: dut%0d ch%0d width %0d, expected no pulse",
                     d, cur_ch[d], run_len[d]);
        end else begin
            e = sb.pop_front();
            chk("pulse_dut", d, e.dut);
            chk($sformatf("pulse_ch_dut%0d", d), cur_ch[d], e.ch);
            chk($sformatf("pulse_width_dut%0d_ch%0d", d, e.ch), run_len[d], e.width);
            if (e.gap >= 0) chk($sformatf("pulse_gap_dut%0d_ch%0d", d, e.ch), start_gap[d], e.gap);
            if (e.lat >= 0) chk($sformatf("pulse_latency_dut%0d_ch%0d", d, e.ch), start_lat[d], e.lat);
        end
    endtask

    // Pulse monitor: measures every pulse on every instance and scores it.
    initial begin
        for (int d = 0; d < NDUT; d++) begin
            run_len[d] = 0;
            gap_cnt[d] = 1000;
            cur_ch[d]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (run_len[d] > 0) begin
                    if (po[d] == (3'b001 << cur_ch[d])) begin
                        run_len[d]++;
                    end else begin
                        finish_pulse(d);
                        run_len[d] = 0;
                        gap_cnt[d] = 0;
                        if (po[d] != 3'b000) start_pulse(d);
                        else gap_cnt[d] = 1;
                    end
                end else if (po[d] != 3'b000) begin
                    start_pulse(d);
                end else begin
                    gap_cnt[d]++;
                end
            end
        end
    end

    task automatic retrig_run(input int d, input int w);
        si[d][0] = 1'b1; mark[d] = cyc + 1;
        push_exp(d, 0, w, -1, 3);
        wait_n(2); si[d][0] = 1'b0;
        wait_n(2); si[d][0] = 1'b1;       // rising edge seen in pulse cycle 3
        wait_n(3);
        chk($sformatf("retrig_pending_dut%0d", d), pend[d], 0);
        wait_n(25);
        chk($sformatf("retrig_sb_empty_dut%0d", d), sb.size(), 0);
        chk($sformatf("retrig_pending_end_dut%0d", d), pend[d], 0);
        si[d][0] = 1'b0;
        wait_n(6);
    endtask

    // Stimulus and state checks.
    initial begin
        int busy_cnt;
        reset = 1'b1;
        si[0] = 3'b000; si[1] = 3'b000; si[2] = 3'b010;
        for (int d = 0; d < NDUT; d++) mark[d] = 0;
        wait_n(3);
        chk("rst_pulse_out", po[0], 0);
        chk("rst_busy", busy_a[0], 0);
        chk("rst_active_ch", ach[0], 0);
        chk("rst_pending", pend[0], 0);
        chk("rst_pulse_out_dut2", po[2], 0);
        reset = 1'b0;
        wait_n(12);
        chk("idle_high_pending_dut2", pend[2], 0);
        chk("idle_high_busy_dut2", busy_a[2], 0);

        // Single request on channel 0
        si[0][0] = 1'b1; mark[0] = cyc + 1;
        push_exp(0, 0, 6, -1, 3);
        wait_n(3);
        chk("single_pending_set", pend[0], 3'b001);
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a[0]) busy_cnt++;
        end
        chk("single_busy_cycles", busy_cnt, 10);
        chk("single_pending_clear", pend[0], 0);
        chk("single_sb_empty", sb.size(), 0);
        si[0][0] = 1'b0;
        wait_n(6);

        // Three simultaneous requests served in priority order
        si[0] = 3'b111; mark[0] = cyc + 1;
        push_exp(0, 0, 6, -1, 3);
        push_exp(0, 1, 2, 5, -1);
        push_exp(0, 2, 32, 5, -1);
        wait_n(3);
        chk("prio_pending_111", pend[0], 3'b111);
        wait_n(1);
        chk("prio_pending_110", pend[0], 3'b110);
        chk("prio_busy", busy_a[0], 1);
        wait_n(11);
        chk("prio_pending_100", pend[0], 3'b100);
        chk("prio_active_ch1", ach[0], 1);
        wait_n(7);
        chk("prio_pending_000", pend[0], 3'b000);
        chk("prio_active_ch2", ach[0], 2);
        wait_n(45);
        chk("prio_sb_empty", sb.size(), 0);
        chk("prio_busy_end", busy_a[0], 0);
        si[0] = 3'b000;
        wait_n(6);

        // Second edge mid-pulse: ignored without retrigger, extends with it
        retrig_run(0, 6);
        retrig_run(1, 9);

        // Falling-edge channel that idled high through reset
        si[2][1] = 1'b0; mark[2] = cyc + 1;
        push_exp(2, 1, 2, -1, 3);
        wait_n(3);
        chk("fall_pending", pend[2], 3'b010);
        wait_n(15);
        chk("fall_sb_empty", sb.size(), 0);
        chk("fall_busy_end", busy_a[2], 0);
        si[2][1] = 1'b1;
        wait_n(6);

        // Zero pulse length and zero holdoff
        si[2] = 3'b111; mark[2] = cyc + 1;
        push_exp(2, 0, 1, -1, 3);
        push_exp(2, 2, 32, 1, -1);
        wait_n(3);
        chk("bound_pending_101", pend[2], 3'b101);
        wait_n(1);
        chk("bound_pending_100", pend[2], 3'b100);
        wait_n(45);
        chk("bound_sb_empty", sb.size(), 0);
        si[2] = 3'b010;
        wait_n(6);

        // Edge on channel 0 exactly in its grant cycle is absorbed
        si[0][2] = 1'b1; mark[0] = cyc + 1;
        push_exp(0, 2, 32, -1, 3);
        push_exp(0, 0, 6, 5, -1);
        wait_n(10); si[0][0] = 1'b1;
        wait_n(10); si[0][0] = 1'b0;
        wait_n(18); si[0][0] = 1'b1;
        wait_n(3);
        chk("absorb_pending_at_grant", pend[0], 3'b000);
        chk("absorb_active_ch", ach[0], 0);
        wait_n(1);
        chk("absorb_pending_after", pend[0], 3'b000);
        wait_n(30);
        chk("absorb_sb_empty", sb.size(), 0);
        si[0] = 3'b000;
        wait_n(6);

        // Reset in channel 2 pulse cycle 10 with channel 1 pending
        si[0][2] = 1'b1; mark[0] = cyc + 1;
        push_exp(0, 2, 10, -1, 3);
        wait_n(5); si[0][1] = 1'b1;
        wait_n(8);
        chk("rstmid_ch1_pending", pend[0], 3'b010);
        reset = 1'b1;
        wait_n(1);
        chk("rstmid_pulse_out", po[0], 0);
        chk("rstmid_busy", busy_a[0], 0);
        chk("rstmid_active_ch", ach[0], 0);
        chk("rstmid_pending", pend[0], 0);
        wait_n(1);
        reset = 1'b0;
        wait_n(50);
        chk("rstmid_sb_empty", sb.size(), 0);
        chk("rstmid_pending_after", pend[0], 0);
        chk("rstmid_busy_after", busy_a[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
